axi4_stream_slave_wrapper: RTL

AXI4-Stream responder for the operand/result link of the AXI4/Avalon comparison testbench. It receives one frame of 2·(SZ/DSZ) beats carrying operands a and b, least-significant byte first, a first. It computes the unsigned product a·b with an iterative shift-add multiplier and returns the 2·SZ-bit product as one frame of 2·(SZ/DSZ) beats, least-significant beat first, with tlast on the final beat. It is the far end of the stream master wrapper: its input stream is the master's to-slave stream, and its output stream is the master's to-master stream.

---
 rtl/axi4_stream_slave_wrapper.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/axi4_stream_slave_wrapper.sv
// axi4_stream_slave_wrapper: AXI4-Stream responder. It receives a and b (LSB
// byte first, a first), multiplies them with an iterative shift-add unit and
// returns the 2*SZ-bit product LSB beat first, with tlast on the final beat.
// Optional build macro: LEN_CHECK_EN. It checks tlast_in against the beat
// position and counts malformed frames in err_count.
module axi4_stream_slave_wrapper #(
    parameter int unsigned SZ  = 32,
    parameter int unsigned DSZ = 8
) (
    input  logic           clk,
    input  logic           _rst,
    input  logic [DSZ-1:0] tdata_in,
    input  logic           tvalid_in,
    output logic           tready_in,
    input  logic           tlast_in,
    output logic [DSZ-1:0] tdata_out,
    output logic           tvalid_out,
    input  logic           tready_out,
    output logic           tlast_out,
    output logic           busy,
    output logic [15:0]    frame_count,
    output logic [7:0]     err_count
);
    localparam int unsigned N  = SZ / DSZ;
    localparam int unsigned F  = 2 * N;
    localparam int unsigned IW = (F > 1) ? $clog2(F) : 1;
    localparam int unsigned CW = $clog2(SZ + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(F - 1);
    localparam logic [CW-1:0] MUL_END  = CW'(SZ);

    typedef enum logic [1:0] {RECV, MUL, SEND} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     beat_idx_q, beat_idx_d;
    logic [IW-1:0]     out_idx_q, out_idx_d;
    logic [IW-1:0]     out_idx_nxt;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [2*SZ-1:0]   ops_q, ops_d;
    logic [2*SZ-1:0]   acc_q, acc_d;
    logic [2*SZ-1:0]   mcand_q, mcand_d;
    logic [SZ-1:0]     mplier_q, mplier_d;
    logic [DSZ-1:0]    tdata_out_q, tdata_out_d;
    logic              tvalid_out_q, tvalid_out_d;
    logic              tlast_out_q, tlast_out_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              in_hs, out_hs, len_err;

    assign tready_in   = (state_q == RECV);
    assign busy        = (state_q != RECV);
    assign tdata_out   = tdata_out_q;
    assign tvalid_out  = tvalid_out_q;
    assign tlast_out   = tlast_out_q;
    assign frame_count = frame_count_q;
    assign in_hs       = tvalid_in & tready_in;
    assign out_hs      = tvalid_out_q & tready_out;
    assign out_idx_nxt = out_idx_q + 1'b1;

`ifdef LEN_CHECK_EN
    logic [7:0] err_count_q, err_count_d;
    assign err_count = err_count_q;
    assign len_err   = (beat_idx_q == LAST_IDX) ? ~tlast_in : tlast_in;
`else
    logic unused_tlast;
    assign unused_tlast = tlast_in;
    assign err_count    = '0;
    assign len_err      = 1'b0;
`endif

    // Next-state, datapath and output-register computation for RECV/MUL/SEND.
    always_comb begin
        state_d       = state_q;
        beat_idx_d    = beat_idx_q;
        out_idx_d     = out_idx_q;
        cyc_d         = cyc_q;
        ops_d         = ops_q;
        acc_d         = acc_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        tdata_out_d   = tdata_out_q;
        tvalid_out_d  = tvalid_out_q;
        tlast_out_d   = tlast_out_q;
        frame_count_d = frame_count_q;
`ifdef LEN_CHECK_EN
        err_count_d   = err_count_q;
`endif
        case (state_q)
            RECV: begin
                if (in_hs) begin
                    if (len_err) begin
                        beat_idx_d = '0;
`ifdef LEN_CHECK_EN
                        if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
`endif
                    end else begin
                        ops_d[beat_idx_q*DSZ +: DSZ] = tdata_in;
                        if (beat_idx_q == LAST_IDX) begin
                            beat_idx_d = '0;
                            state_d    = MUL;
                            cyc_d      = '0;
                            acc_d      = '0;
                            mcand_d    = {{SZ{1'b0}}, ops_d[SZ-1:0]};
                            mplier_d   = ops_d[2*SZ-1:SZ];
                        end else begin
                            beat_idx_d = beat_idx_q + 1'b1;
                        end
                    end
                end
            end
            MUL: begin
                // SZ shift-add steps, then one more cycle to present beat 0,
                // so tvalid_out rises SZ+1 edges after the last input beat.
                if (cyc_q == MUL_END) begin
                    tdata_out_d  = acc_q[DSZ-1:0];
                    tvalid_out_d = 1'b1;
                    tlast_out_d  = 1'b0;
                    out_idx_d    = '0;
                    state_d      = SEND;
                end else begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cyc_d    = cyc_q + 1'b1;
                end
            end
            SEND: begin
                // The accumulator is shifted down one beat per handshake so the
                // next beat is always its low slice.
                if (out_hs) begin
                    if (out_idx_q == LAST_IDX) begin
                        tvalid_out_d  = 1'b0;
                        tlast_out_d   = 1'b0;
                        frame_count_d = frame_count_q + 16'd1;
                        state_d       = RECV;
                    end else begin
                        out_idx_d   = out_idx_nxt;
                        acc_d       = acc_q >> DSZ;
                        tdata_out_d = acc_q[2*DSZ-1:DSZ];
                        tlast_out_d = (out_idx_nxt == LAST_IDX);
                    end
                end
            end
            default: state_d = RECV;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q       <= RECV;
            beat_idx_q    <= '0;
            out_idx_q     <= '0;
            cyc_q         <= '0;
            ops_q         <= '0;
            acc_q         <= '0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            tdata_out_q   <= '0;
            tvalid_out_q  <= 1'b0;
            tlast_out_q   <= 1'b0;
            frame_count_q <= '0;
`ifdef LEN_CHECK_EN
            err_count_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            beat_idx_q    <= beat_idx_d;
            out_idx_q     <= out_idx_d;
            cyc_q         <= cyc_d;
            ops_q         <= ops_d;
            acc_q         <= acc_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            tdata_out_q   <= tdata_out_d;
            tvalid_out_q  <= tvalid_out_d;
            tlast_out_q   <= tlast_out_d;
            frame_count_q <= frame_count_d;
`ifdef LEN_CHECK_EN
            err_count_q   <= err_count_d;
`endif
        end
    end

endmodule
